// File: rtl/posit_quire_stream_accum.sv
// Streaming posit reduction: exact Kulisch-quire accumulation, round-to-nearest-even on the last element.
// Define POSIT_QUIRE_STREAM_ACCUM_COUNT_EN to add the saturating element counter on out_count.
module posit_quire_stream_accum #(
   parameter int WIDTH      = 8,
   parameter int ES         = 1,
   parameter int OVERFLOW   = 0,
   parameter int COUNT_BITS = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   input  logic                  in_negate,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_is_inf
`ifdef POSIT_QUIRE_STREAM_ACCUM_COUNT_EN
   ,
   output logic [COUNT_BITS-1:0] out_count
`endif
);

   // Fraction bits reach minpos; non-fraction bits hold maxpos, the sign and OVERFLOW headroom.
   localparam int MAX_SCALE    = (WIDTH - 2) << ES;
   localparam int FRAC_BITS    = MAX_SCALE;
   localparam int NONFRAC_BITS = MAX_SCALE + 2 + OVERFLOW;
   localparam int QW           = FRAC_BITS + NONFRAC_BITS;
   localparam int XW           = WIDTH + 1 + ES + QW;
   localparam logic [WIDTH-1:0] NAR = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {ACCUM, DRAIN, OUTPUT} state_t;

   function automatic logic [QW-1:0] to_quire(input logic [WIDTH-1:0] p, input logic neg);
      logic [WIDTH-2:0] body, rest;
      logic [ES-1:0]    e;
      logic [QW-1:0]    fixed;
      logic             rbit, done;
      int               run, scale, sh;
      body = p[WIDTH-1] ? -p[WIDTH-2:0] : p[WIDTH-2:0];
      rbit = body[WIDTH-2];
      run  = 0;
      done = 1'b0;
      for (int i = WIDTH - 2; i >= 0; i--) begin
         if (!done && body[i] == rbit) run++;
         else done = 1'b1;
      end
      rest  = body << (run + 1);
      e     = rest[WIDTH-2 -: ES];
      rest  = rest << ES;
      scale = (rbit ? run - 1 : -run) * (1 << ES) + int'(e);
      sh    = scale + FRAC_BITS - (WIDTH - 1);
      fixed = QW'({1'b1, rest});
      fixed = (sh >= 0) ? fixed << sh : fixed >> (-sh);
      if (p[WIDTH-1] ^ neg) fixed = -fixed;
      if (p == '0 || p == NAR) fixed = '0;
      return fixed;
   endfunction

   function automatic logic [WIDTH-1:0] to_posit(input logic [QW-1:0] q);
      logic [QW-1:0]    mag, frac;
      logic [XW-1:0]    tail, regime, x;
      logic [WIDTH-2:0] body;
      logic [WIDTH-1:0] res;
      logic [ES-1:0]    e;
      logic             guard, sticky_bits, up;
      int               msb, scale, k, rl;
      mag = q[QW-1] ? -q : q;
      msb = 0;
      for (int i = 0; i < QW; i++) if (mag[i]) msb = i;
      scale = msb - FRAC_BITS;
      k     = scale >>> ES;
      e     = scale[ES-1:0];
      rl    = (k >= 0) ? k + 2 : 1 - k;
      frac  = mag << (QW - msb);
      // Regime run, terminator, exponent and fraction laid out MSB-first; two trailing bits drive RNE.
      tail   = {e, frac, {(WIDTH+1){1'b0}}} >> rl;
      regime = (k >= 0) ? ~({XW{1'b1}} >> (rl - 1)) : ({1'b1, {(XW-1){1'b0}}} >> (rl - 1));
      x      = regime | tail;
      body        = x[XW-1 -: WIDTH-1];
      guard       = x[XW-WIDTH];
      sticky_bits = |x[XW-WIDTH-1:0];
      up          = guard & (body[0] | sticky_bits);
      body        = body + {{(WIDTH-2){1'b0}}, up};
      if (scale > MAX_SCALE) body = '1;
      res = {1'b0, body};
      if (q[QW-1]) res = -res;
      if (q == '0) res = '0;
      return res;
   endfunction

   state_t        state;
   logic [QW-1:0] s1_fixed, quire;
   logic          s1_valid, s1_last, s1_inf, s2_last, sticky;
   logic          accept, release_out;

   assign accept      = in_valid && in_ready;
   assign release_out = out_valid && out_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ACCUM;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_is_inf <= 1'b0;
         s1_valid   <= 1'b0;
         s1_last    <= 1'b0;
         s1_inf     <= 1'b0;
         s1_fixed   <= '0;
         s2_last    <= 1'b0;
         quire      <= '0;
         sticky     <= 1'b0;
      end else begin
         s1_valid <= accept;
         s1_last  <= accept && in_last;
         s1_inf   <= accept && (in_data == NAR);
         s1_fixed <= to_quire(in_data, in_negate);
         s2_last  <= s1_valid && s1_last;
         if (s1_valid) quire <= quire + s1_fixed;
         if (s1_inf) sticky <= 1'b1;
         case (state)
            ACCUM: if (accept && in_last) begin
               in_ready <= 1'b0;
               state    <= DRAIN;
            end
            DRAIN: if (s2_last) begin
               out_data   <= sticky ? NAR : to_posit(quire);
               out_is_inf <= sticky;
               out_valid  <= 1'b1;
               state      <= OUTPUT;
            end
            OUTPUT: if (release_out) begin
               out_valid <= 1'b0;
               quire     <= '0;
               sticky    <= 1'b0;
               in_ready  <= 1'b1;
               state     <= ACCUM;
            end
            default: state <= ACCUM;
         endcase
      end
   end

`ifdef POSIT_QUIRE_STREAM_ACCUM_COUNT_EN
   logic [COUNT_BITS-1:0] count;

   always_ff @(posedge clock) begin
      if (reset) begin
         count     <= '0;
         out_count <= '0;
      end else begin
         if (release_out) count <= '0;
         else if (accept && count != '1) count <= count + COUNT_BITS'(1);
         if (state == DRAIN && s2_last) out_count <= count;
      end
   end
`endif

endmodule
